hps_ext_mailbox: RTL and testbench
==================================

// Module: hps_ext_mailbox
// PURPOSE
//  Parametrised HPS<->core message mailbox on the 36-bit EXT_BUS. Replaces the single-slot toggle
//  handshake with a DEPTH-entry outbound queue of MSG_WORDS x 16-bit messages and a framed inbound
//  message port. Sits between the HPS EXT_BUS and core-side producers/consumers (MSU, CD, save logic).
// PARAMETERS
//  CMD_GET    'h34  HPS read: pops one outbound message
//  CMD_SET    'h35  HPS write: one inbound message
//  CMD_STAT   'h36  status read; exists only with HPS_EXT_STAT_EN
//  MSG_WORDS  3     16-bit words per message, 1..32
//  DEPTH      8     outbound queue entries, power of 2, 2..256; AW = $clog2(DEPTH)
// PORTS
//  clk_sys    in     1             system clock
//  reset      in     1             asynchronous, active-high
//  EXT_BUS    inout  36            [15:0] io_dout, [31:16] io_din, [32] dout_en, [33] io_strobe, [34] io_enable
//  tx_push    in     1             one-cycle pulse: enqueue tx_data
//  tx_data    in     16*MSG_WORDS  outbound message; word0 = [15:0]
//  tx_full    out    1             queue holds DEPTH entries
//  tx_count   out    AW+1          current occupancy
//  rx_valid   out    1             one-cycle pulse: complete inbound message
//  rx_data    out    16*MSG_WORDS  inbound message; held until next rx_valid
// BEHAVIOUR
//  - Reset: io_dout=0, dout_en=0, queue empty, tx_full=0, tx_count=0, rx_valid=0, rx_data=0, seq=0, word_cnt=0.
//  - After reset deasserts, the bus is ignored until io_enable is sampled low once (no mid-transaction resync).
//  - io_enable low: dout_en=0, io_dout=0, word_cnt=0; end-of-transaction actions fire on the 1->0 edge.
//  - Each io_strobe with io_enable high: word_cnt increments (10 bits, saturates at 1023); io_dout is
//    registered, valid the cycle after the strobe, and defaults to 0.
//  - word_cnt==0: cmd<=io_din; dout_en<=1 iff cmd is a supported code, else 0 for the whole transaction.
//  - GET: word0 response = {seq[7:0], tx_count zero-extended to 8 bits}. Strobes 1..MSG_WORDS return head words
//    0..MSG_WORDS-1; further strobes return 0. If the queue is empty, head words read as 0.
//  - GET pop: on the io_enable fall, pop only if word_cnt>MSG_WORDS and the queue was non-empty. Partial reads never pop.
//  - SET: strobes 1..MSG_WORDS load a shadow buffer. On the io_enable fall, if word_cnt==MSG_WORDS+1 exactly,
//    copy shadow to rx_data and pulse rx_valid for 1 cycle, next cycle. Short or long writes are discarded.
//  - tx_push with the queue not full: enqueue and seq+=1 (8-bit wrap). With the queue full: drop, seq unchanged.
//  - tx_push and pop in the same cycle: always accepted, including when full; tx_count unchanged.
//  - Head words captured for a GET stay stable for that transaction even if pushes occur meanwhile.
//  - Pointers wrap modulo DEPTH. tx_full = (tx_count==DEPTH).
//  - Unsupported cmd: no response and no state change other than word_cnt.
// CONFIGURATION
//  HPS_EXT_STAT_EN defined:
//    - 16-bit saturating drop_cnt increments on each tx_push rejected while full.
//    - CMD_STAT: word0 = {7'b0, tx_full, tx_count[7:0]}, word1 = drop_cnt.
//    - drop_cnt clears on the io_enable fall after a STAT read with word_cnt>=2.
//  HPS_EXT_STAT_EN undefined:
//    - No counter logic.
//    - CMD_STAT is unsupported: dout_en=0 for it.
// STRUCTURE
//  - Package hps_ext_pkg: EXT_BUS bit-position localparams, default command codes, mailbox state enum
//    {ST_WAIT_IDLE, ST_IDLE, ST_CMD_GET, ST_CMD_SET, ST_CMD_STAT, ST_IGNORE}.
//  - Sub-module hps_ext_msg_fifo: synchronous FIFO with DEPTH x (16*MSG_WORDS), push/pop/full/count, same-cycle
//    push+pop when full allowed, async reset.
//  - Top level: bus decode, state machine, shadow buffer, seq/drop counters.
// TESTING
//  1. Push A=48'h0003_0002_0001; GET 'h34 with 4 strobes -> io_dout 16'h0101,1,2,3; dout_en=1; after fall tx_count=0.
//  2. GET with 2 strobes (partial) -> no pop, tx_count stays 1; a repeat full GET returns the same words, then pops.
//  3. SET 'h35 + 3 words AAAA,BBBB,CCCC -> rx_valid 1 cycle, rx_data=48'hCCCC_BBBB_AAAA; SET with 2 words -> no rx_valid.
//  4. Fill 8 entries, 9th push -> tx_full=1, seq=8, entry dropped; push+pop same cycle when full -> count 8, seq=9.
//  5. Assert reset mid-GET after strobe 2 -> all outputs 0, queue empty; strobes ignored until io_enable low.
//  6. STAT_EN: 3 drops, STAT read -> word0 16'h0108, word1 16'h0003, drop_cnt 0 after fall.
//     Without STAT_EN: 'h36 -> dout_en=0.

Source files
------------

// File: rtl/hps_ext_pkg.sv
// rtl/hps_ext_pkg.sv - EXT_BUS bit map, default command codes and mailbox state encoding
package hps_ext_pkg;

  localparam int EXT_DOUT_LSB = 0;
  localparam int EXT_DIN_LSB  = 16;
  localparam int EXT_DOUT_EN  = 32;
  localparam int EXT_STROBE   = 33;
  localparam int EXT_ENABLE   = 34;

  localparam logic [15:0] CMD_GET_DEF  = 16'h0034;
  localparam logic [15:0] CMD_SET_DEF  = 16'h0035;
  localparam logic [15:0] CMD_STAT_DEF = 16'h0036;

  typedef enum logic [2:0] {
    ST_WAIT_IDLE,
    ST_IDLE,
    ST_CMD_GET,
    ST_CMD_SET,
    ST_CMD_STAT,
    ST_IGNORE
  } mbx_state_e;

endpackage

// File: rtl/hps_ext_mailbox_if.sv
// rtl/hps_ext_mailbox_if.sv - EXT_BUS fields; master = HPS side, slave = mailbox side
interface hps_ext_mailbox_if;
  logic [15:0] io_dout;
  logic [15:0] io_din;
  logic        dout_en;
  logic        io_strobe;
  logic        io_enable;

  modport master (output io_din, output io_strobe, output io_enable,
                  input  io_dout, input  dout_en);
  modport slave  (input  io_din, input  io_strobe, input  io_enable,
                  output io_dout, output dout_en);
endinterface

// File: rtl/hps_ext_msg_fifo.sv
// rtl/hps_ext_msg_fifo.sv - DEPTH x WIDTH message queue; push while full is taken when paired with a pop
module hps_ext_msg_fifo #(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 48,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

  // Storage is not reset; the reader masks the head whenever the queue is empty.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/hps_ext_mailbox.sv
// rtl/hps_ext_mailbox.sv - HPS<->core mailbox: outbound queue popped by GET, framed inbound SET port
// Optional status command and drop counter are built when HPS_EXT_STAT_EN is defined.
module hps_ext_mailbox
  import hps_ext_pkg::*;
#(
  parameter  logic [15:0] CMD_GET   = CMD_GET_DEF,
  parameter  logic [15:0] CMD_SET   = CMD_SET_DEF,
  parameter  logic [15:0] CMD_STAT  = CMD_STAT_DEF,
  parameter  int          MSG_WORDS = 3,
  parameter  int          DEPTH     = 8,
  localparam int          AW        = $clog2(DEPTH),
  localparam int          MW        = 16 * MSG_WORDS
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  hps_ext_mailbox_if.slave        EXT_BUS,
  input  logic                    tx_push,
  input  logic [MW-1:0]           tx_data,
  output logic                    tx_full,
  output logic [AW:0]             tx_count,
  output logic                    rx_valid,
  output logic [MW-1:0]           rx_data
);

  localparam logic [9:0] MSG_W = 10'(MSG_WORDS);

  mbx_state_e    state_q, state_d;
  logic [9:0]    word_cnt_q, word_cnt_d;
  logic [15:0]   dout_q, dout_d;
  logic          dout_en_q, dout_en_d;
  logic          head_ok_q, head_ok_d;
  logic [MW-1:0] shadow_q, shadow_d;
  logic          rx_valid_q, rx_valid_d;
  logic [MW-1:0] rx_data_q, rx_data_d;
  logic [7:0]    seq_q, seq_d;
  logic          pop, push_ok;
  logic [MW-1:0] fifo_head;
  logic          fifo_full;
  logic [AW:0]   fifo_count;
  logic [7:0]    cnt8;
`ifdef HPS_EXT_STAT_EN
  logic [15:0]   drop_cnt_q, drop_cnt_d;
  logic          drop_clr;
`endif

  hps_ext_msg_fifo #(.DEPTH(DEPTH), .WIDTH(MW)) u_fifo (
    .clk_i   (clk_sys),
    .rst_i   (reset),
    .push_i  (push_ok),
    .data_i  (tx_data),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

  assign cnt8    = 8'(fifo_count);
  assign push_ok = tx_push && (!fifo_full || pop);

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    dout_d     = '0;
    dout_en_d  = dout_en_q;
    head_ok_d  = head_ok_q;
    shadow_d   = shadow_q;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;
    pop        = 1'b0;
`ifdef HPS_EXT_STAT_EN
    drop_clr   = 1'b0;
`endif
    if (state_q == ST_WAIT_IDLE) begin
      dout_en_d = 1'b0;
      if (!EXT_BUS.io_enable) state_d = ST_IDLE;
    end else if (!EXT_BUS.io_enable) begin
      state_d    = ST_IDLE;
      word_cnt_d = '0;
      dout_en_d  = 1'b0;
      unique case (state_q)
        ST_CMD_GET: pop = head_ok_q && (word_cnt_q > MSG_W);
        ST_CMD_SET: begin
          if (word_cnt_q == MSG_W + 10'd1) begin
            rx_valid_d = 1'b1;
            rx_data_d  = shadow_q;
          end
        end
`ifdef HPS_EXT_STAT_EN
        ST_CMD_STAT: drop_clr = (word_cnt_q >= 10'd2);
`endif
        default: ;
      endcase
    end else if (EXT_BUS.io_strobe) begin
      if (word_cnt_q != 10'd1023) word_cnt_d = word_cnt_q + 10'd1;
      unique case (state_q)
        ST_IDLE: begin
          if (EXT_BUS.io_din == CMD_GET) begin
            state_d   = ST_CMD_GET;
            dout_en_d = 1'b1;
            dout_d    = {seq_q, cnt8};
            // Head stays put until our own pop, so a non-empty flag is enough to freeze it.
            head_ok_d = (fifo_count != '0);
          end else if (EXT_BUS.io_din == CMD_SET) begin
            state_d   = ST_CMD_SET;
            dout_en_d = 1'b1;
`ifdef HPS_EXT_STAT_EN
          end else if (EXT_BUS.io_din == CMD_STAT) begin
            state_d   = ST_CMD_STAT;
            dout_en_d = 1'b1;
            dout_d    = {7'b0, fifo_full, cnt8};
`endif
          end else begin
            state_d   = ST_IGNORE;
            dout_en_d = 1'b0;
          end
        end
        ST_CMD_GET: begin
          for (int i = 0; i < MSG_WORDS; i++) begin
            if (head_ok_q && word_cnt_q == 10'(i + 1)) dout_d = fifo_head[16*i +: 16];
          end
        end
        ST_CMD_SET: begin
          for (int i = 0; i < MSG_WORDS; i++) begin
            if (word_cnt_q == 10'(i + 1)) shadow_d[16*i +: 16] = EXT_BUS.io_din;
          end
        end
`ifdef HPS_EXT_STAT_EN
        ST_CMD_STAT: if (word_cnt_q == 10'd1) dout_d = drop_cnt_q;
`endif
        default: ;
      endcase
    end
  end

  assign seq_d = push_ok ? seq_q + 8'd1 : seq_q;

`ifdef HPS_EXT_STAT_EN
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_clr) drop_cnt_d = '0;
    else if (tx_push && !push_ok && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) drop_cnt_q <= '0;
    else       drop_cnt_q <= drop_cnt_d;
  end
`endif

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q    <= ST_WAIT_IDLE;
      word_cnt_q <= '0;
      dout_q     <= '0;
      dout_en_q  <= 1'b0;
      head_ok_q  <= 1'b0;
      shadow_q   <= '0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      seq_q      <= '0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      dout_q     <= dout_d;
      dout_en_q  <= dout_en_d;
      head_ok_q  <= head_ok_d;
      shadow_q   <= shadow_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      seq_q      <= seq_d;
    end
  end

  assign EXT_BUS.io_dout = dout_q;
  assign EXT_BUS.dout_en = dout_en_q;
  assign tx_full         = fifo_full;
  assign tx_count        = fifo_count;
  assign rx_valid        = rx_valid_q;
  assign rx_data         = rx_data_q;

endmodule

// File: tb/tb_hps_ext_mailbox.sv
// tb/tb_hps_ext_mailbox.sv - directed bench for hps_ext_mailbox (MSG_WORDS=3, DEPTH=8)
module tb_hps_ext_mailbox;
  import hps_ext_pkg::*;

  logic        clk;
  logic        rst;
  logic        tx_push;
  logic [47:0] tx_data;
  logic        tx_full;
  logic [3:0]  tx_count;
  logic        rx_valid;
  logic [47:0] rx_data;
  logic [35:0] ext_view;
  int          n_checks = 0;
  int          n_fail   = 0;

  hps_ext_mailbox_if bus ();

  hps_ext_mailbox #(.MSG_WORDS(3), .DEPTH(8)) dut (
    .clk_sys  (clk),
    .reset    (rst),
    .EXT_BUS  (bus),
    .tx_push  (tx_push),
    .tx_data  (tx_data),
    .tx_full  (tx_full),
    .tx_count (tx_count),
    .rx_valid (rx_valid),
    .rx_data  (rx_data)
  );

  assign ext_view = {1'b0, bus.io_enable, bus.io_strobe, bus.dout_en, bus.io_din, bus.io_dout};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic xfer_word(input logic [15:0] din, output logic [15:0] dout, output logic en);
    bus.io_enable = 1'b1;
    bus.io_strobe = 1'b1;
    bus.io_din    = din;
    tick();
    bus.io_strobe = 1'b0;
    @(negedge clk);
    dout = ext_view[EXT_DOUT_LSB +: 16];
    en   = ext_view[EXT_DOUT_EN];
    tick();
  endtask

  task automatic end_xfer();
    bus.io_enable = 1'b0;
    bus.io_strobe = 1'b0;
    tick();
  endtask

  task automatic push(input logic [47:0] d);
    tx_push = 1'b1;
    tx_data = d;
    tick();
    tx_push = 1'b0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    bus.io_enable = 1'b0;
    bus.io_strobe = 1'b0;
    tx_push = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic get_msg(input logic [15:0] cmd, input int n, output logic [95:0] w, output logic en);
    logic [15:0] d;
    logic        e;
    w = '0;
    xfer_word(cmd, d, en);
    w[15:0] = d;
    for (int i = 1; i <= n; i++) begin
      xfer_word(16'h0000, d, e);
      w[16*i +: 16] = d;
    end
    end_xfer();
  endtask

  task automatic set_msg(input int n, input logic [63:0] d, output logic en,
                         output logic v0, output logic v1, output logic [47:0] rd);
    logic [15:0] dd;
    logic        e;
    xfer_word(CMD_SET_DEF, dd, en);
    for (int i = 0; i < n; i++) xfer_word(d[16*i +: 16], dd, e);
    end_xfer();
    @(negedge clk);
    v0 = rx_valid;
    rd = rx_data;
    tick();
    @(negedge clk);
    v1 = rx_valid;
    tick();
  endtask

  initial begin
    logic [95:0] w;
    logic [47:0] rd;
    logic [15:0] d;
    logic        en, v0, v1;

    rst = 1'b1;
    tx_push = 1'b0;
    tx_data = '0;
    bus.io_enable = 1'b1;
    bus.io_strobe = 1'b0;
    bus.io_din = '0;
    tick();
    @(negedge clk);
    check("rst_dout", ext_view[EXT_DOUT_LSB +: 16], 16'h0);
    check("rst_dout_en", ext_view[EXT_DOUT_EN], 1'b0);
    check("rst_count", tx_count, 4'd0);
    check("rst_full", tx_full, 1'b0);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_rx_data", rx_data, 48'h0);
    reset_dut();

    // basic GET with pop
    push(48'h0003_0002_0001);
    check("t1_count_push", tx_count, 4'd1);
    get_msg(CMD_GET_DEF, 3, w, en);
    check("t1_words", w[63:0], 64'h0003_0002_0001_0101);
    check("t1_dout_en", en, 1'b1);
    check("t1_count_pop", tx_count, 4'd0);

    // partial GET keeps the entry; full GET repeats it then pops
    push(48'h0006_0005_0004);
    get_msg(CMD_GET_DEF, 1, w, en);
    check("t2_partial", w[31:0], 32'h0004_0201);
    check("t2_no_pop", tx_count, 4'd1);
    get_msg(CMD_GET_DEF, 4, w, en);
    check("t2_full_read", w[79:0], 80'h0000_0006_0005_0004_0201);
    check("t2_pop", tx_count, 4'd0);
    get_msg(CMD_GET_DEF, 3, w, en);
    check("t2_empty_get", w[63:0], 64'h0000_0000_0000_0200);
    check("t2_empty_count", tx_count, 4'd0);

    // SET framing
    set_msg(3, 64'h0000_CCCC_BBBB_AAAA, en, v0, v1, rd);
    check("t3_set_en", en, 1'b1);
    check("t3_rx_valid", v0, 1'b1);
    check("t3_rx_pulse", v1, 1'b0);
    check("t3_rx_data", rd, 48'hCCCC_BBBB_AAAA);
    set_msg(2, 64'h0000_0000_2222_1111, en, v0, v1, rd);
    check("t3_short_valid", {v0, v1}, 2'b00);
    check("t3_short_data", rd, 48'hCCCC_BBBB_AAAA);
    set_msg(4, 64'h4444_3333_2222_1111, en, v0, v1, rd);
    check("t3_long_valid", {v0, v1}, 2'b00);
    check("t3_long_data", rd, 48'hCCCC_BBBB_AAAA);

    get_msg(16'h0012, 2, w, en);
    check("unsup_dout_en", en, 1'b0);
    check("unsup_words", w[47:0], 48'h0);

    // fill, drop, push+pop while full
    reset_dut();
    for (int i = 0; i < 8; i++)
      push({16'(16'h0100 * (i + 1) + 2), 16'(16'h0100 * (i + 1) + 1), 16'(16'h0100 * (i + 1))});
    check("t4_count8", tx_count, 4'd8);
    check("t4_full", tx_full, 1'b1);
    push(48'hDEAD_DEAD_DEAD);
    check("t4_drop_count", tx_count, 4'd8);
    xfer_word(CMD_GET_DEF, d, en);
    check("t4_word0", d, 16'h0808);
    for (int i = 0; i < 3; i++) begin
      xfer_word(16'h0000, d, en);
      check("t4_head0", d, 16'(16'h0100 + i));
    end
    bus.io_enable = 1'b0;
    tx_push = 1'b1;
    tx_data = 48'h0E0E_0E0E_0E0E;
    tick();
    tx_push = 1'b0;
    check("t4_pushpop_count", tx_count, 4'd8);
    check("t4_pushpop_full", tx_full, 1'b1);
    get_msg(CMD_GET_DEF, 3, w, en);
    check("t4_seq9_head1", w[63:0], 64'h0202_0201_0200_0908);
    check("t4_count7", tx_count, 4'd7);

    // reset in the middle of a GET
    xfer_word(CMD_GET_DEF, d, en);
    xfer_word(16'h0000, d, en);
    rst = 1'b1;
    #2;
    check("t5_count", tx_count, 4'd0);
    check("t5_full", tx_full, 1'b0);
    check("t5_dout_en", ext_view[EXT_DOUT_EN], 1'b0);
    check("t5_dout", ext_view[EXT_DOUT_LSB +: 16], 16'h0);
    check("t5_rx", {rx_valid, rx_data}, 49'h0);
    tick();
    rst = 1'b0;
    push(48'h0C03_0C02_0C01);
    xfer_word(CMD_GET_DEF, d, en);
    check("t5_ignored_en", en, 1'b0);
    check("t5_ignored_dout", d, 16'h0);
    xfer_word(16'h0000, d, en);
    check("t5_ignored_word", d, 16'h0);
    end_xfer();
    check("t5_no_pop", tx_count, 4'd1);
    get_msg(CMD_GET_DEF, 3, w, en);
    check("t5_resync_en", en, 1'b1);
    check("t5_resync_words", w[63:0], 64'h0C03_0C02_0C01_0101);
    check("t5_resync_pop", tx_count, 4'd0);

`ifdef HPS_EXT_STAT_EN
    reset_dut();
    for (int i = 0; i < 11; i++) push(48'(i));
    get_msg(CMD_STAT_DEF, 1, w, en);
    check("t6_stat_en", en, 1'b1);
    check("t6_stat_words", w[31:0], 32'h0003_0108);
    get_msg(CMD_STAT_DEF, 1, w, en);
    check("t6_drop_cleared", w[31:0], 32'h0000_0108);
`else
    get_msg(CMD_STAT_DEF, 1, w, en);
    check("t6_stat_dout_en", en, 1'b0);
    check("t6_stat_words", w[31:0], 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
